addsub_seq_ctrl: RTL



---
 rtl/addsub_pkg.sv | 14 +
 rtl/addsub_slice8.sv | 30 +++
 rtl/addsub_seq_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared constants for the byte-serial add/sub sequencer.
package addsub_pkg;

  localparam int unsigned SLICE_W = 8;

  // Controller state encoding (kept as fixed constants for legacy compatibility)
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_slice8.sv
// Combinational 8-bit adder built from four 2-bit carry-lookahead stages.
// Exposes the carry into bit 7 so the caller can derive signed overflow.
module addsub_slice8 (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co,
  output logic       c7
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  assign g    = x & y;
  assign p    = x ^ y;
  assign c[0] = ci;

  // Each stage resolves both of its carries directly from the stage carry-in
  for (genvar i = 0; i < 4; i++) begin : g_cla2
    assign c[2*i+1] = g[2*i] | (p[2*i] & c[2*i]);
    assign c[2*i+2] = g[2*i+1] | (p[2*i+1] & g[2*i]) | (p[2*i+1] & p[2*i] & c[2*i]);
  end

  assign s  = p ^ c[7:0];
  assign co = c[8];
  assign c7 = c[7];

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Byte-serial wide add/subtract sequencer around one shared 8-bit slice.
// Processes LSB byte first, one byte per cycle, with a registered carry.
module addsub_seq_ctrl
  import addsub_pkg::*;
#(
  parameter  int unsigned N_SLICES = 2,
  localparam int unsigned W        = SLICE_W * N_SLICES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         op_sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovr
);

  localparam int unsigned CW = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;

  logic [1:0]         state_q,  state_d;
  logic [CW-1:0]      cnt_q,    cnt_d;
  logic               carry_q,  carry_d;
  logic               sub_q,    sub_d;
  logic [W-1:0]       a_q,      a_d;
  logic [W-1:0]       b_q,      b_d;
  logic [W-1:0]       result_q, result_d;
  logic               cout_q,   cout_d;
  logic               ovr_q,    ovr_d;

  logic [SLICE_W-1:0] sx, sy, ss;
  logic               sco, sc7;
  logic               last;

  assign last = (cnt_q == CW'(N_SLICES - 1));

  // Select the current operand bytes; B is inverted here for subtraction
  always_comb begin
    sx = '0;
    sy = '0;
    for (int unsigned k = 0; k < N_SLICES; k++) begin
      if (cnt_q == CW'(k)) begin
        sx = a_q[k*SLICE_W +: SLICE_W];
        sy = b_q[k*SLICE_W +: SLICE_W] ^ {SLICE_W{sub_q}};
      end
    end
  end

  addsub_slice8 u_slice (
    .x  (sx),
    .y  (sy),
    .ci (carry_q),
    .s  (ss),
    .co (sco),
    .c7 (sc7)
  );

  // FSM and datapath next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovr_d    = ovr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = op_sub;
          carry_d = (op_sub == OP_SUB);
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int unsigned k = 0; k < N_SLICES; k++) begin
          if (cnt_q == CW'(k)) begin
            result_d[k*SLICE_W +: SLICE_W] = ss;
          end
        end
        carry_d = sco;
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          cout_d  = sco;
          ovr_d   = sc7 ^ sco;
          cnt_d   = '0;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovr_q    <= ovr_d;
    end
  end

  assign ready  = (state_q == IDLE);
  assign busy   = (state_q == RUN);
  assign done   = (state_q == FIN);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovr    = ovr_q;

endmodule
